// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter slice: op encodings,
// datapath widths and the response-stage state type.
package shift_arb_pkg;

  localparam int unsigned SFT_W   = 32;
  localparam int unsigned SFT_SHW = 5;

  typedef logic [1:0] sft_op_t;

  localparam sft_op_t SFT_SLL = 2'b00;
  localparam sft_op_t SFT_SRL = 2'b01;
  localparam sft_op_t SFT_SRA = 2'b10;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic [SFT_W-1:0] bit_rev(input logic [SFT_W-1:0] v);
    for (int unsigned i = 0; i < SFT_W; i++) bit_rev[i] = v[SFT_W-1-i];
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit logarithmic shifter (16/8/4/2/1 stages).
// Op 11 behaves as SRA.
module shift_core
  import shift_arb_pkg::*;
(
  output logic [SFT_W-1:0]   y,
  input  logic [SFT_W-1:0]   a,
  input  logic [SFT_SHW-1:0] shamt,
  input  sft_op_t            op
);

  logic             left;
  logic             fill;
  logic [SFT_W-1:0] stage [0:SFT_SHW];

  // Left shifts reuse the right-shift stages on the bit-reversed operand.
  always_comb begin
    left     = (op == SFT_SLL);
    fill     = op[1] & a[SFT_W-1];
    stage[0] = left ? bit_rev(a) : a;
    for (int unsigned i = 0; i < SFT_SHW; i++) begin
      int unsigned      k;
      logic [SFT_W-1:0] mask;
      k    = (SFT_W / 2) >> i;
      mask = fill ? ~({SFT_W{1'b1}} >> k) : '0;
      stage[i+1] = shamt[SFT_SHW-1-i] ? ((stage[i] >> k) | mask) : stage[i];
    end
    y = left ? bit_rev(stage[SFT_SHW]) : stage[SFT_SHW];
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one barrel shifter between NREQ requesters with a
// one-entry registered response stage. Optional op_cnt under SHIFT_ARB_CNT_EN.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*5-1:0]    req_shamt,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_y,
  output logic [IDW-1:0]       rsp_id
`ifdef SHIFT_ARB_CNT_EN
  ,
  output logic [31:0]          op_cnt
`endif
);

  rsp_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       win;
  logic [IDW-1:0]       nxt_ptr;
  logic                 found;
  logic                 can_accept;
  logic                 accept;
  logic [SFT_W-1:0]     sel_a;
  logic [SFT_SHW-1:0]   sel_shamt;
  sft_op_t              sel_op;
  logic [SFT_W-1:0]     sft_y;

  assign can_accept = (state_q == RSP_EMPTY) || rsp_ready;
  assign accept     = found && can_accept;
  assign nxt_ptr    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  // First valid requester at or after rr_ptr wins; its payload feeds the shifter.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    sel_a     = '0;
    sel_shamt = '0;
    sel_op    = SFT_SLL;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = (32'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        win       = IDW'(j);
        sel_a     = req_a[SFT_W*j +: SFT_W];
        sel_shamt = req_shamt[SFT_SHW*j +: SFT_SHW];
        sel_op    = req_op[2*j +: 2];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  shift_core u_core (
    .y     (sft_y),
    .a     (sel_a),
    .shamt (sel_shamt),
    .op    (sel_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RSP_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                                  state_d = RSP_FULL;
    else if (state_q == RSP_FULL && rsp_ready)   state_d = RSP_EMPTY;
  end

  always_comb begin
    rsp_valid = (state_q == RSP_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y    <= '0;
      rsp_id   <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      rsp_y    <= sft_y;
      rsp_id   <= win;
      rr_ptr_q <= nxt_ptr;
    end
  end

`ifdef SHIFT_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     op_cnt <= '0;
    else if (rsp_valid && rsp_ready) op_cnt <= op_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, hand-written
// reset/contention/backpressure sequences and a randomized model comparison.
module tb_shift_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*5-1:0]   req_shamt = '0;
  logic [NREQ*2-1:0]   req_op = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [31:0]         rsp_y;
  logic [IDW-1:0]      rsp_id;
`ifdef SHIFT_ARB_CNT_EN
  logic [31:0]         op_cnt;
`endif

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_CNT_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned who;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [31:0] a,
                         input logic [4:0] s, input logic [1:0] o);
    req_valid[i]       = v;
    req_a[32*i +: 32]  = a;
    req_shamt[5*i +: 5] = s;
    req_op[2*i +: 2]   = o;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n     = 1'b1;
    step();
  endtask

  function automatic logic [31:0] sft_ref(input logic [31:0] a, input logic [4:0] s,
                                          input logic [1:0] o);
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      default: return 32'($signed(a) >>> s);
    endcase
  endfunction

  // Reference model state
  logic        m_valid;
  logic [31:0] m_y;
  int unsigned m_id;
  int unsigned m_ptr;
  logic [31:0] m_cnt;
  logic [NREQ-1:0] held;

  initial begin
    vecs[0]  = '{0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
    vecs[1]  = '{1, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
    vecs[2]  = '{1, 32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000};
    vecs[3]  = '{1, 32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000};
    vecs[4]  = '{1, 32'h8000_0000, 5'd0,  2'b00, 32'h8000_0000};
    vecs[5]  = '{1, 32'h8000_0000, 5'd0,  2'b01, 32'h8000_0000};
    vecs[6]  = '{1, 32'h8000_0000, 5'd0,  2'b10, 32'h8000_0000};
    vecs[7]  = '{0, 32'hF000_000F, 5'd4,  2'b00, 32'h0000_00F0};
    vecs[8]  = '{0, 32'hF000_000F, 5'd4,  2'b01, 32'h0F00_0000};
    vecs[9]  = '{0, 32'hF000_000F, 5'd4,  2'b10, 32'hFF00_0000};
    vecs[10] = '{1, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    vecs[11] = '{1, 32'hFFFF_FFFF, 5'd1,  2'b00, 32'hFFFF_FFFE};

    #2;
    do_reset();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_y", rsp_y, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
`ifdef SHIFT_ARB_CNT_EN
    chk("reset_op_cnt", op_cnt, 32'd0);
`endif

    // Directed vector table, single requester at a time
    rsp_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      set_req(0, 1'b0, $urandom, 5'($urandom), 2'($urandom));
      set_req(1, 1'b0, $urandom, 5'($urandom), 2'($urandom));
      set_req(vecs[v].who, 1'b1, vecs[v].a, vecs[v].sh, vecs[v].op);
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1) << vecs[v].who);
      step();
      chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'd1);
      chk($sformatf("vec%0d_y", v), rsp_y, vecs[v].y);
      chk($sformatf("vec%0d_id", v), 32'(rsp_id), vecs[v].who);
      req_valid = '0;
    end

    // Async reset while holding a response with rr_ptr=1
    do_reset();
    set_req(0, 1'b1, 32'h0000_00FF, 5'd4, 2'b00);
    step();
    req_valid = '0;
    step();
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_y", rsp_y, 32'd0);
`ifdef SHIFT_ARB_CNT_EN
    chk("async_reset_cnt", op_cnt, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'h1234_5678, 5'd8, 2'b00);
    set_req(1, 1'b1, 32'h8765_4321, 5'd8, 2'b01);
    rsp_ready = 1'b1;
    #1;
    chk("post_reset_prio", 32'(req_ready), 32'd1);

    // Contention: alternating grants, one response per cycle
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("cont%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("cont%0d_id", k), 32'(rsp_id), 32'(k % 2));
      chk($sformatf("cont%0d_y", k), rsp_y, (k % 2 == 0) ? 32'h3456_7800 : 32'h0087_6543);
      #1;
      chk($sformatf("cont%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd2 : 32'd1);
    end

    // Backpressure: last response (id 1) must hold for 3 cycles
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready_drop", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_y", k), rsp_y, 32'h0087_6543);
      chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'd1);
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    chk("bp_release_id", 32'(rsp_id), 32'd0);
    chk("bp_release_y", rsp_y, 32'h3456_7800);

`ifdef SHIFT_ARB_CNT_EN
    req_valid = '0;
    rsp_ready = 1'b0;
    force dut.op_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.op_cnt;
    rsp_ready = 1'b1;
    step();
    chk("cnt_wrap", op_cnt, 32'd0);
`endif

    // Randomized run against the reference model
    do_reset();
    m_valid = 1'b0;
    m_y     = '0;
    m_id    = 0;
    m_ptr   = 0;
    m_cnt   = '0;
    held    = '0;
    for (int c = 0; c < 400; c++) begin
      logic        can;
      int          w;
      logic [NREQ-1:0] exp_rdy;
      chk("rnd_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rnd_y", rsp_y, m_y);
      chk("rnd_id", 32'(rsp_id), m_id);
`ifdef SHIFT_ARB_CNT_EN
      chk("rnd_cnt", op_cnt, m_cnt);
`endif
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!(held[i] && $urandom_range(0, 7) != 0))
          set_req(i, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)));
      end
      #1;
      can = !m_valid || rsp_ready;
      w   = -1;
      for (int unsigned k = 0; k < NREQ; k++) begin
        int unsigned j;
        j = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[j]) w = int'(j);
      end
      exp_rdy = '0;
      if (can && w >= 0) exp_rdy[w] = 1'b1;
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_valid && rsp_ready) m_cnt = m_cnt + 32'd1;
      if (can && w >= 0) begin
        m_y     = sft_ref(req_a[32*w +: 32], req_shamt[5*w +: 5], req_op[2*w +: 2]);
        m_id    = w;
        m_valid = 1'b1;
        m_ptr   = (w + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      held = req_valid & ~exp_rdy;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares a single 32-bit barrel shifter between `NREQ` requesters, for example the integer pipe and a bit-manipulation/CSR helper. Each requester has a valid/ready port. A work-conserving round-robin arbiter grants at most one request per cycle. The granted operation is computed combinationally and captured in a one-entry registered response stage, which is returned with the requester ID under valid/ready backpressure.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the response ID.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, `NREQ`: request valid, one bit per requester.
- `req_ready`, out, `NREQ`: one-hot grant/accept.
- `req_a`, in, `NREQ*32`: operand A, requester i in slice `[32*i+31:32*i]`.
- `req_shamt`, in, `NREQ*5`: shift amount, requester i in slice `[5*i+4:5*i]`.
- `req_op`, in, `NREQ*2`: operation; 00 SLL, 01 SRL, 10/11 SRA.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_y`, out, 32: shift result.
- `rsp_id`, out, `IDW`: index of the requester that owns `rsp_y`.

## Operation
- Output stage has two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_accept` = EMPTY, or FULL with `rsp_ready`=1.
- Arbitration:
  - Search starts at `rr_ptr` and wraps modulo `NREQ`.
  - The first requester with `req_valid`=1 wins, provided `can_accept`=1.
  - `req_ready` is one-hot or all-zero.
  - It is 0 for requesters with `req_valid`=0.
- On accept (`req_valid[i] & req_ready[i]`):
  - `rsp_y` ← shift(`req_a[i]`, `req_shamt[i]`, `req_op[i]`).
  - `rsp_id` ← i.
  - State → FULL.
  - `rr_ptr` ← (i+1) mod `NREQ`.
- Drain with no accept in the same cycle: state → EMPTY. `rsp_y` and `rsp_id` keep their values.
- No grant: `rr_ptr` unchanged.
- Shift semantics:
  - Shift amount is 0..31; shamt 0 returns A unchanged.
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with A[31].
- Simultaneous drain and accept: the new result replaces the old one in the same edge, with no bubble.
- Requesters hold payload and valid stable until accepted. Dropping valid before accept is legal; that request is discarded.
- While FULL and `rsp_ready`=0: `rsp_y`, `rsp_id` and `rsp_valid` are stable, and all `req_ready` are 0.

## Timing
- Reset values: `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rr_ptr`=0, `req_ready`=0.
- Reset mid-operation discards any held response immediately (asynchronous). After release, requester 0 has top priority.
- Latency: accept in cycle N gives `rsp_valid`=1 with the result in cycle N+1.
- Throughput: 1 op/cycle while `rsp_ready`=1.
- Combinational paths (documented; integrator must budget for them):
  - `req_valid` → `req_ready`
  - `rsp_ready` → `req_ready`
- There is no combinational path from request inputs to `rsp_*`.
- Fairness: a continuously valid requester waits at most `NREQ-1` grants.

## Configuration
- `SHIFT_ARB_CNT_EN` defined:
  - Adds output `op_cnt` [31:0]. It increments by 1 on every response handshake (`rsp_valid & rsp_ready`) and wraps from 0xFFFF_FFFF to 0.
  - Reset value of `op_cnt` is 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `shift_arb_pkg`:
  - Op constants `SFT_SLL`=2'b00, `SFT_SRL`=2'b01, `SFT_SRA`=2'b10.
  - `SFT_W`=32 and `SFT_SHW`=5.
  - A typedef for the op field.
- Sub-module `shift_core`:
  - Purely combinational 5-stage (16/8/4/2/1) logarithmic shifter.
  - Ports: `y`, `a`, `shamt`, `op`.
  - Op 11 is treated as SRA.
- Top level contains the round-robin pointer, grant logic, output register and optional counter.

## Test plan
- SLL, requester 0: a=0x0000_0001, shamt=31, op=00 → next cycle `rsp_valid`=1, `rsp_y`=0x8000_0000, `rsp_id`=0.
- Shift variants, requester 1, a=0x8000_0000:
  - shamt=4, op=10 → 0xF800_0000, id=1; op=11 gives the same result.
  - shamt=4, op=01 → 0x0800_0000.
  - shamt=0, any op → 0x8000_0000.
- Contention: both requesters valid continuously, `rsp_ready`=1 → grants 0,1,0,1,…; one response per cycle; IDs alternate; no bubbles.
- Backpressure: response pending, `rsp_ready`=0 for 3 cycles → `rsp_y`/`rsp_id` stable and `req_ready`=0. Raising `rsp_ready` drains the pending response and accepts the next request in the same cycle.
- Reset: assert `rst_n` low while `rsp_valid`=1 and `rr_ptr`=1 → `rsp_valid`=0 without waiting for a clock. After release with both requesters valid, requester 0 is granted first. With `SHIFT_ARB_CNT_EN`, `op_cnt`=0.
- Counter wrap (`SHIFT_ARB_CNT_EN`): force `op_cnt` to 0xFFFF_FFFF, complete one handshake → `op_cnt`=0.
